// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle unsigned multiply/divide unit with a single register-file write-back beat.
// It takes one iteration per clock: shift-add for multiply and restoring division for divide.
module iterative_muldiv_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [WIDTH-1:0]      operand_a,
  input  logic [WIDTH-1:0]      operand_b,
  input  logic [REG_ADDR_W-1:0] dest,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] result_rd,
  output logic                  result_we,
  output logic                  div_by_zero
);

  // state | meaning
  // IDLE  | waiting for start, outputs hold last completion
  // RUN   | one shift-add / restoring-divide iteration per edge
  // DONE  | done/result_we pulse for one cycle

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT                 state;
  logic [CNT_W-1:0]      count;
  logic [1:0]            opReg;
  logic [WIDTH-1:0]      opA;
  logic [WIDTH-1:0]      opB;
  logic [REG_ADDR_W-1:0] destReg;
  logic [2*WIDTH-1:0]    prodAcc;
  logic [WIDTH-1:0]      rem;
  logic [WIDTH-1:0]      quo;
  logic                  busyReg;
  logic                  doneReg;
  logic [WIDTH-1:0]      resultReg;
  logic [REG_ADDR_W-1:0] resultRdReg;
  logic                  divZeroReg;

  logic [WIDTH:0]        mulSum;
  logic [2*WIDTH-1:0]    prodNext;
  logic [WIDTH:0]        remShift;
  logic [WIDTH:0]        remDiff;
  logic [WIDTH-1:0]      remNext;
  logic [WIDTH-1:0]      quoNext;
  logic [WIDTH-1:0]      finalResult;

  always_comb begin
    mulSum   = {1'b0, prodAcc[2*WIDTH-1:WIDTH]} + (prodAcc[0] ? {1'b0, opA} : '0);
    prodNext = {mulSum, prodAcc[WIDTH-1:1]};

    // A restore only happens when remShift < opB, so its top bit is zero there.
    remShift = {rem, quo[WIDTH-1]};
    remDiff  = remShift - {1'b0, opB};
    if (remDiff[WIDTH]) begin
      remNext = remShift[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b0};
    end else begin
      remNext = remDiff[WIDTH-1:0];
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end

    case (opReg)
      2'b00:   finalResult = prodNext[WIDTH-1:0];
      2'b01:   finalResult = prodNext[2*WIDTH-1:WIDTH];
      2'b10:   finalResult = quoNext;
      default: finalResult = remNext;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      opReg       <= '0;
      opA         <= '0;
      opB         <= '0;
      destReg     <= '0;
      prodAcc     <= '0;
      rem         <= '0;
      quo         <= '0;
      busyReg     <= 1'b0;
      doneReg     <= 1'b0;
      resultReg   <= '0;
      resultRdReg <= '0;
      divZeroReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            count      <= '0;
            opReg      <= op;
            opA        <= operand_a;
            opB        <= operand_b;
            destReg    <= dest;
            prodAcc    <= {{WIDTH{1'b0}}, operand_b};
            rem        <= '0;
            quo        <= operand_a;
            busyReg    <= 1'b1;
            divZeroReg <= 1'b0;
          end
        end
        RUN: begin
          prodAcc <= prodNext;
          rem     <= remNext;
          quo     <= quoNext;
          count   <= count + 1'b1;
          if (count == LAST_COUNT) begin
            state       <= DONE;
            doneReg     <= 1'b1;
            resultReg   <= finalResult;
            resultRdReg <= destReg;
            divZeroReg  <= opReg[1] && (opB == '0);
          end
        end
        DONE: begin
          state   <= IDLE;
          doneReg <= 1'b0;
          busyReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          doneReg <= 1'b0;
          busyReg <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busyReg;
  assign done        = doneReg;
  assign result_we   = doneReg;
  assign result      = resultReg;
  assign result_rd   = resultRdReg;
  assign div_by_zero = divZeroReg;

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Table-driven bench for iterative_muldiv_unit, plus sequences that cover ignored starts and
// reset arriving mid-operation.
module tb_iterative_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic [2:0]  dest;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  result_rd;
  logic        result_we;
  logic        div_by_zero;

  int nTests = 0;
  int nFail  = 0;

  iterative_muldiv_unit #(.WIDTH(16), .REG_ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .dest(dest),
    .busy(busy), .done(done), .result(result), .result_rd(result_rd),
    .result_we(result_we), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dest;
    logic [15:0] expRes;
    logic        expDz;
  } vecT;

  vecT vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, then track it to completion. lat is the number of falling edges from the accept edge to the done cycle.
  task automatic runOp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, output int lat, output int busyCnt);
    @(negedge clock);
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest = d;
    @(posedge clock);
    #1;
    start = 1'b0; op = 2'($urandom); operand_a = 16'($urandom);
    operand_b = 16'($urandom); dest = 3'($urandom);
    lat = 0; busyCnt = 0;
    while (!done && lat < 40) begin
      @(negedge clock);
      lat++;
      if (busy) busyCnt++;
    end
  endtask

  initial begin
    int lat, busyCnt, doneCnt, doneAt;
    logic [15:0] capRes;
    logic [2:0]  capRd;

    vecs[0]  = '{2'b00, 16'd7,     16'd6,     3'd3, 16'd42,    1'b0};
    vecs[1]  = '{2'b01, 16'hFFFF,  16'hFFFF,  3'd4, 16'hFFFE,  1'b0};
    vecs[2]  = '{2'b00, 16'hFFFF,  16'hFFFF,  3'd6, 16'h0001,  1'b0};
    vecs[3]  = '{2'b10, 16'd100,   16'd7,     3'd5, 16'd14,    1'b0};
    vecs[4]  = '{2'b11, 16'd100,   16'd7,     3'd5, 16'd2,     1'b0};
    vecs[5]  = '{2'b10, 16'd1234,  16'd0,     3'd2, 16'hFFFF,  1'b1};
    vecs[6]  = '{2'b11, 16'd1234,  16'd0,     3'd7, 16'd1234,  1'b1};
    vecs[7]  = '{2'b01, 16'd7,     16'd6,     3'd1, 16'h0000,  1'b0};
    vecs[8]  = '{2'b10, 16'd7,     16'd100,   3'd0, 16'd0,     1'b0};
    vecs[9]  = '{2'b11, 16'd7,     16'd100,   3'd3, 16'd7,     1'b0};
    vecs[10] = '{2'b01, 16'h1234,  16'h0100,  3'd2, 16'h0012,  1'b0};
    vecs[11] = '{2'b00, 16'h1234,  16'h0100,  3'd4, 16'h3400,  1'b0};
    vecs[12] = '{2'b10, 16'hFFFF,  16'd1,     3'd6, 16'hFFFF,  1'b0};

    reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_rd", 32'(result_rd), 32'd0);
    check("reset_we", 32'(result_we), 32'd0);
    check("reset_dz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, lat, busyCnt);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd17);
      check($sformatf("v%0d_busy_cycles", i), 32'(busyCnt), 32'd17);
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].expRes));
      check($sformatf("v%0d_rd", i), 32'(result_rd), 32'(vecs[i].dest));
      check($sformatf("v%0d_we", i), 32'(result_we), 32'd1);
      check($sformatf("v%0d_dz", i), 32'(div_by_zero), 32'(vecs[i].expDz));
      @(negedge clock);
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_idle", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_hold", i), 32'(result), 32'(vecs[i].expRes));
    end

    // Starts issued at E5 and in the DONE cycle must both be dropped.
    @(negedge clock);
    start = 1'b1; op = 2'b00; operand_a = 16'd3; operand_b = 16'd4; dest = 3'd1;
    @(posedge clock);
    #1;
    start = 1'b0; op = 2'b10; operand_a = 16'd9; operand_b = 16'd3; dest = 3'd2;
    doneCnt = 0; doneAt = 0; capRes = '0; capRd = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i == 18) check("ign_idle_after_done", 32'(busy), 32'd0);
      if (done) begin
        doneCnt++; doneAt = i; capRes = result; capRd = result_rd;
        start = 1'b1;
      end else begin
        start = (i == 5);
      end
    end
    start = 1'b0;
    check("ign_done_count", 32'(doneCnt), 32'd1);
    check("ign_done_at", 32'(doneAt), 32'd17);
    check("ign_result", 32'(capRes), 32'd12);
    check("ign_rd", 32'(capRd), 32'd1);
    check("ign_hold", 32'(result), 32'd12);
    runOp(2'b10, 16'd9, 16'd3, 3'd2, lat, busyCnt);
    check("after_ign_latency", 32'(lat), 32'd17);
    check("after_ign_result", 32'(result), 32'd3);
    check("after_ign_rd", 32'(result_rd), 32'd2);

    // A reset pulse sampled at E8 aborts the op in flight.
    @(negedge clock);
    start = 1'b1; op = 2'b00; operand_a = 16'd5; operand_b = 16'd5; dest = 3'd4;
    @(posedge clock);
    #1;
    start = 1'b0;
    doneCnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (done) doneCnt++;
      if (i == 8) reset = 1'b1;
      if (i == 9) begin
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_rd", 32'(result_rd), 32'd0);
        check("abort_we", 32'(result_we), 32'd0);
        reset = 1'b0;
      end
    end
    check("abort_no_done", 32'(doneCnt), 32'd0);
    runOp(2'b00, 16'd2, 16'd3, 3'd6, lat, busyCnt);
    check("after_abort_latency", 32'(lat), 32'd17);
    check("after_abort_result", 32'(result), 32'd6);
    check("after_abort_rd", 32'(result_rd), 32'd6);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
